l2_norm_sqrt: RTL and testbench
===============================

# l2_norm_sqrt

Iterative integer square-root unit that turns the 20-bit sum-of-squares produced by the byte accumulator into the final L2 norm. It sits directly downstream of the accumulator: its `valid_in`/`s` pins are driven by the accumulator's `valid_out`/`f`. It produces `floor(sqrt(s))` using a restoring digit-by-digit algorithm that resolves one result bit per cycle. It applies backpressure through `ready`.

## Interface

Parameters:
- `IN_W`, default 20: input width. Must be even and ≥ 2.
- `OUT_W`, default `IN_W/2`: root width. Derived; do not override.

Ports:
- `clk`, input, 1: clock.
- `reset`, input, 1: reset, synchronous, active-high.
- `s`, input, IN_W: radicand (sum of squares). Sampled only on the accept edge.
- `valid_in`, input, 1: radicand valid.
- `ready`, output, 1: unit can accept a radicand this cycle.
- `root`, output, OUT_W: `floor(sqrt(s))`. Registered; holds until the next result.
- `valid_out`, output, 1: one-cycle pulse marking a new `root`.
- `rem`, output, OUT_W+1: `s - root²`. Present only with `L2_SQRT_REMAINDER_EN` defined.

## Operation

- **Accept:** a radicand is accepted on a rising edge where `valid_in && ready`. If `valid_in` is high while `ready` is low, the radicand is not captured. The upstream must hold `s`/`valid_in` until accepted.
- **FSM states:** IDLE, CALC, DONE.
  - IDLE: `ready=1`. On accept: load operand = `s`, partial root = 0, partial remainder = 0, iteration counter = 0, go to CALC. Otherwise stay in IDLE.
  - CALC: `ready=0`. Each cycle performs one iteration:
    - Shift the top 2 operand bits into the remainder: `r' = {r, op[IN_W-1:IN_W-2]}`; shift the operand left by 2.
    - Form `trial = {q, 2'b01}`.
    - If `r' ≥ trial`: `r = r' - trial`, `q = {q, 1}`. Else: `r = r'`, `q = {q, 0}`.
    - After the `OUT_W`-th iteration (counter = OUT_W-1): register `root = q_final` (and `rem`), go to DONE.
  - DONE: `valid_out=1`, `ready=1`.
    - If accept in this cycle: go to CALC with a fresh load (back-to-back).
    - Otherwise go to IDLE.
- **Widths:**
  - Partial remainder register is OUT_W+2 bits; the trial compare/subtract is unsigned at OUT_W+2 bits.
  - Final remainder ≤ `2*root`, so it fits in OUT_W+1 bits.
  - The counter is `$clog2(OUT_W)` bits.
- **Boundary values:**
  - `s=0` gives root 0, rem 0.
  - `s=2^IN_W-1` gives root `2^OUT_W-1`, rem `2^(OUT_W+1)-2`. There is no overflow.
- **Reset mid-operation:** the FSM returns to IDLE and the in-flight result is discarded. No `valid_out` follows.

## Timing

- Reset values: `ready=1`, `valid_out=0`, `root=0`, `rem=0`; state IDLE.
- Latency: if the accept edge is k, iterations occur at edges k+1…k+OUT_W. `root`/`rem` update at edge k+OUT_W. `valid_out` is high for exactly the cycle following edge k+OUT_W (10 cycles after accept for the default widths).
- Throughput: one result per OUT_W+1 cycles (11 cycles default) with back-to-back accepts in DONE.
- `ready` is a registered-state decode (IDLE or DONE). It has no combinational path from `valid_in`.
- `root` is stable from `valid_out` until the next result's update edge.

## Configuration

- `L2_SQRT_REMAINDER_EN` defined: the `rem` port exists and is registered alongside `root` at the same edge.
- `L2_SQRT_REMAINDER_EN` undefined: there is no `rem` port, and the final remainder is not registered. Iteration logic is unchanged, and `root`/timing are identical.

## Structure

- Package `l2_pkg`:
  - `L2_IN_W` (20) and `L2_OUT_W` (10) constants, shared with the accumulator.
  - `sqrt_state_t` enum {IDLE, CALC, DONE}.
- Sub-module `l2_sqrt_step`: purely combinational single iteration. Inputs are `r`, `q`, and the 2 operand bits; outputs are `r_next` and `q_next`. The top module holds the FSM, counter, and registers, and instantiates one step.

## Test plan

- **Reset values:** after reset, check `ready=1`, `valid_out=0`, `root=0`, `rem=0`. Then accept `s=0` and check `root=0`, `rem=0`, `valid_out` exactly 10 cycles after accept.
- **Known values:**
  - `s=1` gives root 1, rem 0.
  - `s=1000` gives root 31, rem 39.
  - `s=260100` (4·255²) gives root 510, rem 0.
- **Maximum input:** `s=20'hFFFFF` gives root 1023, rem 2046.
- **Backpressure and back-to-back:**
  - Hold `valid_in` high with `s=100`, then `s=99` → `ready` is low during CALC, and the second radicand is accepted in the DONE cycle.
  - Results are 10 (rem 0) and 9 (rem 18), with `valid_out` pulses 11 cycles apart.
  - `s` changes while `ready` is low are ignored.
- **Reset mid-operation:** assert `reset` during CALC iteration 5 → `valid_out` never pulses, and the state is IDLE with `ready=1`.
- **Randomized sweep:** random `s` against a reference `floor(sqrt)` model. Check `root² ≤ s < (root+1)²` and, when enabled, `rem = s - root²`.

Source files
------------

// File: rtl/l2_norm_sqrt_pkg.sv
// l2_norm_sqrt_pkg: widths shared with the byte accumulator and the square-root FSM states.
package l2_pkg;
  localparam int L2_IN_W = 20;
  localparam int L2_OUT_W = L2_IN_W / 2;
  typedef enum logic [1:0] {IDLE, CALC, DONE} sqrt_state_t;
endpackage

// File: rtl/l2_norm_sqrt_if.sv
// l2_norm_sqrt_if: radicand/result handshake between the accumulator and the sqrt unit.
// The rem signal exists only when L2_SQRT_REMAINDER_EN is defined.
interface l2_norm_sqrt_if import l2_pkg::*; #(parameter int IN_W = L2_IN_W);
  localparam int OUT_W = IN_W / 2;
  logic [IN_W-1:0] s;
  logic valid_in;
  logic ready;
  logic [OUT_W-1:0] root;
  logic valid_out;
`ifdef L2_SQRT_REMAINDER_EN
  logic [OUT_W:0] rem;
  modport master (output s, valid_in, input ready, root, valid_out, rem);
  modport slave (input s, valid_in, output ready, root, valid_out, rem);
`else
  modport master (output s, valid_in, input ready, root, valid_out);
  modport slave (input s, valid_in, output ready, root, valid_out);
`endif
endinterface

// File: rtl/l2_norm_sqrt_step.sv
// l2_sqrt_step: one restoring digit-by-digit square-root iteration (one root bit).
module l2_sqrt_step #(parameter int OUT_W = 10) (
  input  logic [OUT_W+1:0] r,
  input  logic [OUT_W-1:0] q,
  input  logic [1:0]       bits,
  output logic [OUT_W+1:0] r_next,
  output logic [OUT_W-1:0] q_next
);
  logic [OUT_W+1:0] r_sh, trial;
  logic ge;
  always_comb begin
    r_sh = (OUT_W+2)'({r, bits});
    trial = {q, 2'b01};
    ge = r_sh >= trial;
    r_next = ge ? r_sh - trial : r_sh;
    q_next = OUT_W'({q, ge});
  end
endmodule

// File: rtl/l2_norm_sqrt.sv
// l2_norm_sqrt: iterative floor(sqrt(s)), one result bit per cycle; L2_SQRT_REMAINDER_EN adds rem.
module l2_norm_sqrt import l2_pkg::*; #(
  parameter int IN_W = L2_IN_W,
  parameter int OUT_W = IN_W / 2
) (
  input logic clk,
  input logic reset,
  l2_norm_sqrt_if.slave io
);
  localparam int CW = OUT_W > 1 ? $clog2(OUT_W) : 1;
  sqrt_state_t state_q, state_d;
  logic [IN_W-1:0] op_q, op_d;
  logic [OUT_W+1:0] r_q, r_d, r_nx;
  logic [OUT_W-1:0] q_q, q_d, q_nx, root_q, root_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ready, valid_out, accept, calc, last;
  assign accept = io.valid_in && ready;
  assign calc = state_q == CALC;
  assign last = calc && cnt_q == CW'(OUT_W - 1);
  l2_sqrt_step #(.OUT_W(OUT_W)) u_step (
    .r(r_q), .q(q_q), .bits(op_q[IN_W-1 -: 2]), .r_next(r_nx), .q_next(q_nx)
  );
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  end
  // IDLE and DONE share the same transitions: accept starts a fresh load
  always_comb begin
    state_d = calc ? (last ? DONE : CALC) : (accept ? CALC : IDLE);
  end
  always_comb begin
    ready = state_q != CALC;
    valid_out = state_q == DONE;
  end
  always_comb begin
    op_d = accept ? io.s : (calc ? op_q << 2 : op_q);
    r_d = accept ? '0 : (calc ? r_nx : r_q);
    q_d = accept ? '0 : (calc ? q_nx : q_q);
    cnt_d = accept ? '0 : (calc ? cnt_q + 1'b1 : cnt_q);
    root_d = last ? q_nx : root_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q <= '0;
      r_q <= '0;
      q_q <= '0;
      cnt_q <= '0;
      root_q <= '0;
    end else begin
      op_q <= op_d;
      r_q <= r_d;
      q_q <= q_d;
      cnt_q <= cnt_d;
      root_q <= root_d;
    end
  end
  assign io.ready = ready;
  assign io.valid_out = valid_out;
  assign io.root = root_q;
`ifdef L2_SQRT_REMAINDER_EN
  logic [OUT_W:0] rem_q, rem_d;
  always_comb begin
    rem_d = last ? r_nx[OUT_W:0] : rem_q;
  end
  always_ff @(posedge clk) begin
    if (reset) rem_q <= '0;
    else rem_q <= rem_d;
  end
  assign io.rem = rem_q;
`endif
endmodule

// File: tb/tb_l2_norm_sqrt.sv
// tb_l2_norm_sqrt: scoreboard bench for l2_norm_sqrt against a floor(sqrt) reference.
module tb_l2_norm_sqrt;
  import l2_pkg::*;
  localparam int LAT = L2_OUT_W;
  typedef struct {
    logic [19:0] s;
    int acc;
  } item_t;
  logic clk = 0;
  logic reset = 1;
  always #5 clk = ~clk;
  l2_norm_sqrt_if #(.IN_W(L2_IN_W)) io();
  l2_norm_sqrt dut (.clk(clk), .reset(reset), .io(io.slave));
  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  bit mon_en = 0;
  item_t sb[$];
  item_t it;
  int d;
  longint rt, ss;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint isqrt(input longint v);
    longint r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  always @(negedge clk) if (mon_en) begin
    if (sb.size() == 0) chk("idle_valid", longint'(io.valid_out), 0);
    else if (cyc - sb[0].acc >= 0) begin
      d = cyc - sb[0].acc;
      chk("ready", longint'(io.ready), longint'(d >= LAT));
      chk("valid_lat", longint'(io.valid_out), longint'(d == LAT));
      if (io.valid_out) begin
        it = sb.pop_front();
        ss = longint'(it.s);
        rt = longint'(io.root);
        chk("root", rt, isqrt(ss));
        chk("sq_lo", longint'(rt * rt <= ss), 1);
        chk("sq_hi", longint'(ss < (rt + 1) * (rt + 1)), 1);
`ifdef L2_SQRT_REMAINDER_EN
        chk("rem", longint'(io.rem), ss - isqrt(ss) * isqrt(ss));
`endif
      end
    end
  end

  task automatic send(input logic [19:0] v);
    int n = 0;
    io.valid_in = 1;
    while (!io.ready && n < 60) begin
      io.s = 20'($urandom);
      @(negedge clk);
      n++;
    end
    if (!io.ready) begin
      chk("accept_timeout", 0, 1);
      return;
    end
    io.s = v;
    sb.push_back('{v, cyc + 1});
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    io.valid_in = 0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int n;
    io.s = 0;
    io.valid_in = 0;
    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("rst_ready", longint'(io.ready), 1);
    chk("rst_valid", longint'(io.valid_out), 0);
    chk("rst_root", longint'(io.root), 0);
`ifdef L2_SQRT_REMAINDER_EN
    chk("rst_rem", longint'(io.rem), 0);
`endif
    mon_en = 1;
    send(20'd0);
    idle(15);
    send(20'd1);
    send(20'd1000);
    send(20'd260100);
    send(20'hFFFFF);
    idle(15);
    send(20'd100);
    send(20'd99);
    idle(15);
    send(20'd12345);
    io.valid_in = 0;
    repeat (4) @(negedge clk);
    reset = 1;
    sb.delete();
    @(negedge clk);
    reset = 0;
    chk("midrst_ready", longint'(io.ready), 1);
    chk("midrst_valid", longint'(io.valid_out), 0);
    idle(15);
    for (int i = 0; i < 40; i++) begin
      send(20'($urandom_range(0, 20'hFFFFF)));
      if ($urandom_range(0, 3) == 0) idle(2);
    end
    io.valid_in = 0;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) chk("drain", longint'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
